// File: rtl/clk_div_pkg.sv
// Shared types and constants for the run-time clock divider controller.
//   state_t : controller FSM state (IDLE, RUN, STOPPING)
//   MIN_DIV : smallest divisor the counter can realise
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int unsigned MIN_DIV = 2;

    // Divider produces output in both active states.
    function automatic logic is_active(input state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Config / output bundle for clk_div_ctrl.
//   en, cfg_valid, cfg_div : driven by the config master
//   cfg_ready, cfg_err     : handshake status back to the master
//   tick, div_out, running : divider outputs to strobe consumers
interface clk_div_ctrl_if #(
    parameter int unsigned CNT_W = 8
) ();

    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             tick;
    logic             div_out;
    logic             running;

    modport master (
        output en, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, tick, div_out, running
    );

    modport slave (
        input  en, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, tick, div_out, running
    );

endinterface

// File: rtl/clk_div_core.sv
// Period counter with registered tick and div_out.
//   clk, reset : clock, async active-high reset
//   run        : divider is active in the coming cycle
//   div_n      : divisor governing the coming cycle
//   tick       : registered, high in the last cycle of a period
//   div_out    : registered, high while count < div_n>>1
// Both outputs are computed from the next-state count so the pins are
// straight flop outputs.
module clk_div_core #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [CNT_W-1:0] div_n,
    output logic             tick,
    output logic             div_out
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_n;
    logic             run_q;
    logic             tick_n;
    logic             div_out_n;

    // Next count: restart at 0 on start-up and after a wrap, hold 0 when idle.
    // count_q+1 only happens below div_n-1, so it never overflows.
    always_comb begin
        count_n   = '0;
        if (run && run_q && !tick) begin
            count_n = count_q + CNT_W'(1);
        end
        tick_n    = run && (count_n == (div_n - CNT_W'(1)));
        div_out_n = run && (count_n < (div_n >> 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            run_q   <= 1'b0;
            tick    <= 1'b0;
            div_out <= 1'b0;
        end else begin
            count_q <= count_n;
            run_q   <= run;
            tick    <= tick_n;
            div_out <= div_out_n;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the programmable divide-by-N clock divider.
//   clk, reset : clock, async active-high reset
//   bus        : clk_div_ctrl_if slave port
//                en (run level), cfg_valid/cfg_div/cfg_ready (divisor handshake),
//                cfg_err (rejected divisor pulse), tick, div_out, running
// Ratio changes and stops only take effect at a period wrap (tick cycle).
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic           clk,
    input  logic           reset,
    clk_div_ctrl_if.slave  bus
);

    localparam int unsigned      MAX_DIV = (32'd1 << CNT_W) - 32'd1;
    localparam logic [CNT_W-1:0] DEF_N   = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_N   = CNT_W'(MIN_DIV);

    if (DEFAULT_DIV < MIN_DIV || DEFAULT_DIV > MAX_DIV) begin : g_bad_default
        $error("clk_div_ctrl: DEFAULT_DIV must satisfy 2 <= DEFAULT_DIV < 2**CNT_W");
    end

    state_t           state_q, state_n;
    logic [CNT_W-1:0] div_q,   div_n;
    logic [CNT_W-1:0] pend_q,  pend_n;
    logic             ready_q, ready_n;
    logic             err_q,   err_n;
    logic             running_q;
    logic             core_tick;
    logic             accept;
    logic             bad_div;

    assign accept  = bus.cfg_valid && ready_q;
    assign bad_div = bus.cfg_div < MIN_N;

    // Next-state: FSM, active divisor, pending slot and handshake.
    // A pending change exists exactly while cfg_ready is low.
    always_comb begin
        state_n = state_q;
        div_n   = div_q;
        pend_n  = pend_q;
        ready_n = ready_q;
        err_n   = 1'b0;

        unique case (state_q)
            IDLE:     if (bus.en) state_n = RUN;
            RUN:      if (!bus.en) state_n = STOPPING;
            STOPPING: begin
                if (bus.en) begin
                    state_n = RUN;
                end else if (core_tick) begin
                    state_n = IDLE;
                end
            end
            default:  state_n = IDLE;
        endcase

        // Deferred change lands on the wrap, even when stopping there.
        if (!ready_q && core_tick) begin
            div_n   = pend_q;
            ready_n = 1'b1;
        end

        if (accept) begin
            if (bad_div) begin
                err_n = 1'b1;
            end else if (state_q == IDLE || core_tick) begin
                // Nothing in flight, or the current period ends now: apply directly.
                div_n = bus.cfg_div;
            end else begin
                pend_n  = bus.cfg_div;
                ready_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= DEF_N;
            pend_q    <= '0;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            div_q     <= div_n;
            pend_q    <= pend_n;
            ready_q   <= ready_n;
            err_q     <= err_n;
            running_q <= is_active(state_n);
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .run     (is_active(state_n)),
        .div_n   (div_n),
        .tick    (core_tick),
        .div_out (bus.div_out)
    );

    assign bus.tick      = core_tick;
    assign bus.cfg_ready = ready_q;
    assign bus.cfg_err   = err_q;
    assign bus.running   = running_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl (CNT_W=8, DEFAULT_DIV=2).
module tb_clk_div_ctrl;

    logic clk;
    logic reset;

    clk_div_ctrl_if #(.CNT_W(8)) bus ();

    clk_div_ctrl #(
        .CNT_W       (8),
        .DEFAULT_DIV (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic t;
        logic d;
        logic r;
        logic rdy;
        logic err;
    } exp_t;

    typedef struct packed {
        logic       en;
        logic       v;
        logic [7:0] div;
        exp_t       exp;
    } vec_t;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    exp_t        sb_q[$];
    int          cnt_q[$];
    vec_t        tbl[34];

    function automatic vec_t mk(input logic en, input logic v, input int div,
                                input logic t, input logic d, input logic r,
                                input logic rdy, input logic err);
        vec_t x;
        x.en  = en;
        x.v   = v;
        x.div = 8'(div);
        x.exp = '{t: t, d: d, r: r, rdy: rdy, err: err};
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        chk({tag, ".tick"},      int'(bus.tick),      int'(e.t));
        chk({tag, ".div_out"},   int'(bus.div_out),   int'(e.d));
        chk({tag, ".running"},   int'(bus.running),   int'(e.r));
        chk({tag, ".cfg_ready"}, int'(bus.cfg_ready), int'(e.rdy));
        chk({tag, ".cfg_err"},   int'(bus.cfg_err),   int'(e.err));
    endtask

    // Drive one cycle of inputs; the expectation is for the cycle after the edge.
    task automatic step(input string tag, input vec_t v);
        exp_t e;
        bus.en        = v.en;
        bus.cfg_valid = v.v;
        bus.cfg_div   = v.div;
        sb_q.push_back(v.exp);
        cyc();
        e = sb_q.pop_front();
        check_outs(tag, e);
    endtask

    initial begin
        int per;
        int high;
        int guard;

        // en, valid, div | tick, div_out, running, cfg_ready, cfg_err (next cycle)
        tbl[0]  = mk(1, 0, 0,   0, 1, 1, 1, 0);  // start, N=2, count 0
        tbl[1]  = mk(1, 0, 0,   1, 0, 1, 1, 0);
        tbl[2]  = mk(1, 0, 0,   0, 1, 1, 1, 0);
        tbl[3]  = mk(1, 0, 0,   1, 0, 1, 1, 0);
        tbl[4]  = mk(1, 1, 4,   0, 1, 1, 1, 0);  // offered on tick: N=4 next period
        tbl[5]  = mk(1, 0, 0,   0, 1, 1, 1, 0);  // count 1
        tbl[6]  = mk(1, 1, 5,   0, 0, 1, 0, 0);  // pending 5, ready drops
        tbl[7]  = mk(1, 1, 9,   1, 0, 1, 0, 0);  // ignored while not ready
        tbl[8]  = mk(1, 1, 9,   0, 1, 1, 1, 0);  // ignored; N=5 applied, ready back
        tbl[9]  = mk(1, 0, 0,   0, 1, 1, 1, 0);
        tbl[10] = mk(1, 1, 1,   0, 0, 1, 1, 1);  // cfg_div=1 rejected
        tbl[11] = mk(1, 0, 0,   0, 0, 1, 1, 0);
        tbl[12] = mk(1, 0, 0,   1, 0, 1, 1, 0);
        tbl[13] = mk(1, 1, 0,   0, 1, 1, 1, 1);  // cfg_div=0 on tick rejected, N stays 5
        tbl[14] = mk(1, 0, 0,   0, 1, 1, 1, 0);
        tbl[15] = mk(1, 0, 0,   0, 0, 1, 1, 0);
        tbl[16] = mk(1, 0, 0,   0, 0, 1, 1, 0);
        tbl[17] = mk(1, 0, 0,   1, 0, 1, 1, 0);
        tbl[18] = mk(1, 1, 6,   0, 1, 1, 1, 0);  // N=6
        tbl[19] = mk(1, 0, 0,   0, 1, 1, 1, 0);
        tbl[20] = mk(1, 0, 0,   0, 1, 1, 1, 0);  // count 2
        tbl[21] = mk(0, 0, 0,   0, 0, 1, 1, 0);  // en dropped: count 3
        tbl[22] = mk(0, 0, 0,   0, 0, 1, 1, 0);
        tbl[23] = mk(0, 0, 0,   1, 0, 1, 1, 0);  // count 5 tick
        tbl[24] = mk(0, 0, 0,   0, 0, 0, 1, 0);  // idle
        tbl[25] = mk(0, 0, 0,   0, 0, 0, 1, 0);
        tbl[26] = mk(1, 0, 0,   0, 1, 1, 1, 0);  // restart count 0
        tbl[27] = mk(1, 0, 0,   0, 1, 1, 1, 0);
        tbl[28] = mk(0, 0, 0,   0, 1, 1, 1, 0);  // stopping, count 2
        tbl[29] = mk(0, 0, 0,   0, 0, 1, 1, 0);
        tbl[30] = mk(0, 0, 0,   0, 0, 1, 1, 0);  // count 4
        tbl[31] = mk(1, 0, 0,   1, 0, 1, 1, 0);  // re-raised: count 5
        tbl[32] = mk(1, 0, 0,   0, 1, 1, 1, 0);  // no gap
        tbl[33] = mk(1, 0, 0,   0, 1, 1, 1, 0);

        reset         = 1'b1;
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        cyc();
        cyc();
        check_outs("reset", '{t: 1'b0, d: 1'b0, r: 1'b0, rdy: 1'b1, err: 1'b0});
        reset = 1'b0;

        for (int i = 0; i < 34; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Wait for the wrap and bypass-load the maximum divisor there.
        guard = 0;
        while (!bus.tick && guard < 20) begin
            cyc();
            guard++;
        end
        chk("n255.tick_before_load", int'(bus.tick), 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 8'd255;
        cyc();
        bus.cfg_valid = 1'b0;
        chk("n255.ready_after_load", int'(bus.cfg_ready), 1);

        cnt_q.push_back(255);
        cnt_q.push_back(127);
        per  = 1;
        high = int'(bus.div_out);
        while (!bus.tick && per < 300) begin
            cyc();
            per++;
            high += int'(bus.div_out);
        end
        chk("n255.tick_seen", int'(bus.tick), 1);
        chk("n255.period", per, cnt_q.pop_front());
        chk("n255.high_cycles", high, cnt_q.pop_front());

        // Graceful stop, then load a divisor while idle.
        bus.en = 1'b0;
        guard  = 0;
        while (bus.running && guard < 600) begin
            cyc();
            guard++;
        end
        chk("stop.running", int'(bus.running), 0);

        step("idle_load", mk(0, 1, 8,   0, 0, 0, 1, 0));
        step("n8.c0",     mk(1, 0, 0,   0, 1, 1, 1, 0));
        step("n8.c1",     mk(1, 0, 0,   0, 1, 1, 1, 0));
        step("n8.pend",   mk(1, 1, 5,   0, 1, 1, 0, 0));
        step("n8.c3",     mk(1, 0, 0,   0, 1, 1, 0, 0));

        // Asynchronous reset mid-period with a change pending.
        #2;
        reset = 1'b1;
        #1;
        check_outs("async_reset", '{t: 1'b0, d: 1'b0, r: 1'b0, rdy: 1'b1, err: 1'b0});
        #3;
        reset = 1'b0;

        step("post_reset.c0", mk(1, 0, 0,   0, 1, 1, 1, 0));
        step("post_reset.c1", mk(1, 0, 0,   1, 0, 1, 1, 0));
        step("post_reset.c2", mk(1, 0, 0,   0, 1, 1, 1, 0));
        step("post_reset.c3", mk(1, 0, 0,   1, 0, 1, 1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
